// File: rtl/bp_dyn_pkg.sv
// Shared types for the LC-3b dynamic branch predictor.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package bp_dyn_pkg;

    // Branch class of the instruction resolving in MEM
    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_COND   = 2'd1,
        BR_UNCOND = 2'd2
    } lc3b_br_kind;

    // BTB half of a table entry; the direction counter lives in its own sat_ctr.
    // The tag field is sized for the smallest index width and zero-extended.
    typedef struct packed {
        logic        valid;
        logic        uncond;
        logic [14:0] tag;
        logic [15:0] target;
    } bp_entry_t;

    // Prediction fields carried down the pipe so MEM can detect a mispredict
    typedef struct packed {
        logic        predicted_branch;
        logic [15:0] predicted_target;
    } lc3b_control_word;

    // Fall-through address of a word-aligned instruction, wrapping at 2^16
    function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/bp_dyn_if.sv
// Fetch-side prediction and MEM-side resolution bundle for bp_dyn.
// Latency: wires only.
// Backpressure: none; every signal is sampled every cycle.
interface bp_dyn_if #(
    parameter int STAT_BITS = 16
);
    import bp_dyn_pkg::*;

    logic [15:0]          fetch_pc;
    logic                 pred_taken;
    logic [15:0]          pred_target;

    logic                 res_valid;
    lc3b_br_kind          res_kind;
    logic [15:0]          res_pc;
    logic                 res_taken;
    logic [15:0]          res_target;
    logic                 res_pred_taken;
    logic [15:0]          res_pred_target;

    logic                 flush;
    logic [15:0]          redirect_pc;
    logic [STAT_BITS-1:0] stat_branches;
    logic [STAT_BITS-1:0] stat_misses;

    // Pipeline side
    modport master (
        output fetch_pc, res_valid, res_kind, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        input  pred_taken, pred_target, flush, redirect_pc,
               stat_branches, stat_misses
    );

    // Predictor side
    modport slave (
        input  fetch_pc, res_valid, res_kind, res_pc, res_taken, res_target,
               res_pred_taken, res_pred_target,
        output pred_taken, pred_target, flush, redirect_pc,
               stat_branches, stat_misses
    );

endinterface

// File: rtl/bp_dyn_sat_ctr.sv
// Saturating up/down counter with parallel load and parametrised reset value.
// Latency: 1 cycle from inc/dec/load to cnt_o.
// Backpressure: none; inc at all-ones and dec at zero are ignored.
module sat_ctr #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, then saturating increment, then saturating decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bp_dyn.sv
// Direct-mapped counter table + tagged BTB predictor with MEM-stage training.
// Latency: prediction and flush/redirect are combinational; training lands next cycle.
// Backpressure: none; one fetch lookup and one resolution accepted every cycle.
module bp_dyn
    import bp_dyn_pkg::*;
#(
    parameter int IDX_BITS  = 4,
    parameter int CTR_BITS  = 2,
    parameter int STAT_BITS = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    bp_dyn_if.slave  bp
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - 1'b1;

    // Bit 0 of an LC-3b PC is always zero, so the index starts at bit 1
    function automatic logic [IDX_BITS-1:0] idx_of(input logic [15:0] pc);
        return pc[IDX_BITS:1];
    endfunction

    function automatic logic [14:0] tag_of(input logic [15:0] pc);
        return {{IDX_BITS{1'b0}}, pc[15:IDX_BITS+1]};
    endfunction

    bp_entry_t           btb_q [DEPTH];
    bp_entry_t           btb_d [DEPTH];
    logic [CTR_BITS-1:0] ctr_w [DEPTH];

    // ---------------- prediction ----------------
    logic [IDX_BITS-1:0] f_idx;
    bp_entry_t           f_ent;
    logic [CTR_BITS-1:0] f_ctr;
    logic                f_hit;

    assign f_idx = idx_of(bp.fetch_pc);
    assign f_ent = btb_q[f_idx];
    assign f_ctr = ctr_w[f_idx];
    assign f_hit = f_ent.valid && (f_ent.tag == tag_of(bp.fetch_pc));

    // Unconditional entries always predict taken; conditional ones follow the counter MSB
    always_comb begin
        bp.pred_taken  = 1'b0;
        bp.pred_target = 16'h0000;
        if (rst_n && f_hit && (f_ent.uncond || f_ctr[CTR_BITS-1])) begin
            bp.pred_taken  = 1'b1;
            bp.pred_target = f_ent.target;
        end
    end

    // ---------------- resolution ----------------
    logic                res_act;
    logic                res_cond;
    logic                r_taken;
    logic [IDX_BITS-1:0] r_idx;
    logic [14:0]         r_tag;
    logic                r_hit;
    logic                mispredict;

    assign res_act  = rst_n && bp.res_valid && (bp.res_kind != BR_NONE);
    assign res_cond = res_act && (bp.res_kind == BR_COND);
    // Jumps, calls and traps are always taken even if the pipe says otherwise
    assign r_taken  = bp.res_taken || (bp.res_kind == BR_UNCOND);
    assign r_idx    = idx_of(bp.res_pc);
    assign r_tag    = tag_of(bp.res_pc);
    assign r_hit    = btb_q[r_idx].valid && (btb_q[r_idx].tag == r_tag);

    assign mispredict = res_act &&
                        ((r_taken != bp.res_pred_taken) ||
                         (r_taken && (bp.res_pred_target != bp.res_target)));

    // Flush steers fetch to the real target, or to the fall-through on a wrong taken guess
    always_comb begin
        bp.flush       = 1'b0;
        bp.redirect_pc = 16'h0000;
        if (mispredict) begin
            bp.flush       = 1'b1;
            bp.redirect_pc = r_taken ? bp.res_target : pc_plus2(bp.res_pc);
        end
    end

    // ---------------- training ----------------
    // Taken branches (re)allocate the BTB slot; not-taken conditionals leave it alone
    always_comb begin
        btb_d = btb_q;
        if (res_act && r_taken) begin
            btb_d[r_idx] = '{valid:  1'b1,
                             uncond: (bp.res_kind == BR_UNCOND),
                             tag:    r_tag,
                             target: bp.res_target};
        end
    end

    // BTB storage; valid clears on reset so no stale target can be predicted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

    // One direction counter per entry; a tag miss restarts it at the weak state
    // matching the observed outcome instead of inheriting another branch's history
    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
        logic sel;
        assign sel = res_cond && (r_idx == IDX_BITS'(i));

        sat_ctr #(
            .W       (CTR_BITS),
            .RST_VAL (CTR_WNT)
        ) u_ctr (
            .clk        (clk),
            .rst_n      (rst_n),
            .inc_i      (sel && r_hit && r_taken),
            .dec_i      (sel && r_hit && !r_taken),
            .load_i     (sel && !r_hit),
            .load_val_i (r_taken ? CTR_WT : CTR_WNT),
            .cnt_o      (ctr_w[i])
        );
    end

    // ---------------- statistics ----------------
    sat_ctr #(
        .W       (STAT_BITS),
        .RST_VAL ('0)
    ) u_stat_branches (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (res_act),
        .dec_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (bp.stat_branches)
    );

    sat_ctr #(
        .W       (STAT_BITS),
        .RST_VAL ('0)
    ) u_stat_misses (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (mispredict),
        .dec_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (bp.stat_misses)
    );

endmodule
